multsigned_decoder_stream: RTL

//  Streaming decoder for packed 4-bit sign-magnitude weight codes {sign, mag[2:0]}.

---
 rtl/multsigned_pkg.sv | 18 +
 rtl/multsigned_code_dec.sv | 32 +++
 rtl/multsigned_decoder_stream.sv | 101 ++++++++++
 3 files changed

// File: rtl/multsigned_pkg.sv
// Shared types and helpers for the sign-magnitude weight-code decoder.
package multsigned_pkg;

  localparam int CODE_W = 4;
  localparam int MAG_W  = 3;
  localparam logic [MAG_W-1:0] MAG_MAX = 3'd4;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } wcode_t;

  // Negative zero and magnitudes above MAG_MAX have no meaning in the weight set.
  function automatic logic is_legal(input wcode_t c);
    return (c.mag <= MAG_MAX) && !(c.sign && (c.mag == '0));
  endfunction

endpackage

// File: rtl/multsigned_code_dec.sv
// One-lane combinational decode: sign-magnitude code -> two's-complement (mag << SHIFT).
module multsigned_code_dec
  import multsigned_pkg::*;
#(
  parameter int OUT_W = 5,
  parameter int SHIFT = 1
) (
  input  logic [CODE_W-1:0] code,
  output logic [OUT_W-1:0]  val,
  output logic              err
);

  wcode_t                   c;
  logic signed [OUT_W-1:0]  mag_ext;
  logic signed [OUT_W-1:0]  shifted;

  assign c = wcode_t'(code);

  always_comb begin
    mag_ext = {{(OUT_W-MAG_W){1'b0}}, c.mag};
    shifted = mag_ext <<< SHIFT;
    err     = !is_legal(c);
    // Illegal lanes contribute nothing to the MAC rather than a garbage weight.
    if (err)
      val = '0;
    else if (c.sign)
      val = -shifted;
    else
      val = shifted;
  end

endmodule

// File: rtl/multsigned_decoder_stream.sv
// Streaming weight-code decoder with a 2-entry output FIFO.
// Optional macro DECODER_ERR_CNT_EN adds err_cnt_o/err_clr_i (saturating illegal-beat counter).
module multsigned_decoder_stream
  import multsigned_pkg::*;
#(
  parameter int LANES = 4,
  parameter int OUT_W = 5,
  parameter int SHIFT = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [LANES*CODE_W-1:0] in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*OUT_W-1:0] out_data_o,
`ifdef DECODER_ERR_CNT_EN
  output logic [15:0]            err_cnt_o,
  input  logic                   err_clr_i,
`endif
  output logic [LANES-1:0]       out_err_o
);

  localparam int DW = LANES*OUT_W;

  logic [DW-1:0]    dec_data_p0;
  logic [LANES-1:0] dec_err_p0;
  logic             vld_p0;

  logic [DW-1:0]    buf_data_p1 [2];
  logic [LANES-1:0] buf_err_p1  [2];
  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             vld_p1;
  logic             push;
  logic             pop;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    multsigned_code_dec #(
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
    ) u_dec (
      .code (in_data_i[g*CODE_W +: CODE_W]),
      .val  (dec_data_p0[g*OUT_W +: OUT_W]),
      .err  (dec_err_p0[g])
    );
  end

  // ---- p0 -> p1: decoded beat enters the FIFO ----
  assign in_ready_o = (count != 2'd2);
  assign vld_p0     = in_valid_i;
  assign push       = vld_p0 && in_ready_o;
  assign vld_p1     = (count != 2'd0);
  assign pop        = vld_p1 && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_data_p1[wr_ptr] <= dec_data_p0;
      buf_err_p1[wr_ptr]  <= dec_err_p0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; gating by valid gives clean zeros whenever the FIFO is empty.
  assign out_valid_o = vld_p1;
  assign out_data_o  = vld_p1 ? buf_data_p1[rd_ptr] : '0;
  assign out_err_o   = vld_p1 ? buf_err_p1[rd_ptr]  : '0;

`ifdef DECODER_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      err_cnt_q <= 16'd0;
    else if (err_clr_i)
      err_cnt_q <= 16'd0;
    else if (push && (|dec_err_p0) && (err_cnt_q != 16'hFFFF))
      err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule
